regfile_dump: RTL and testbench
===============================

# regfile_dump

Sequential maintenance port for the RV32I register file. On command it either streams all 32 architectural registers out over a valid/ready interface or clears x1–x31 to zero. It drives the register file's second read port and its write port while the core is held stalled, and serves as the debug/test-harness counterpart to the datapath's register accesses.

## Interface
Parameters:
- XLEN, 32, register width
- NREGS, 32, number of registers walked (x0..x(NREGS-1))
- AW, 5, register address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command pulse, sampled only in IDLE
- clear  in  1  command select, sampled with start: 0 = dump, 1 = clear
- busy  out  1  high in every state except IDLE; core must stall and yield register-file ports while high
- done  out  1  one-cycle pulse at command completion
- AddR  out  AW  register-file read address
- DataR  in  XLEN  register-file read data, combinational from AddR
- WE  out  1  register-file write enable
- AddD  out  AW  register-file write address
- DataD  out  XLEN  register-file write data, always 0
- out_valid  out  1  dump word valid
- out_ready  in  1  consumer accepts the dump word
- out_data  out  XLEN  dumped register value
- out_index  out  AW  register number of out_data

## Operation
- FSM states: IDLE, READ, HOLD, CLR, DONE. Index counter idx is AW bits wide.
- IDLE:
  - start=1, clear=0 → idx=0, go to READ.
  - start=1, clear=1 → idx=1, go to CLR.
  - start=0 → stay in IDLE.
- READ: AddR=idx. On the next edge: out_data←DataR, out_index←idx, out_valid←1, go to HOLD.
- HOLD:
  - out_valid=1; out_data and out_index held stable until handshake.
  - On out_valid&out_ready: out_valid←0. If idx==NREGS-1, go to DONE; otherwise idx←idx+1, go to READ.
- CLR: WE=1, AddD=idx, DataD=0. Each edge: if idx==NREGS-1, go to DONE; otherwise idx←idx+1. x0 is never addressed.
- DONE: done=1 for one cycle, then go to IDLE.
- WE, AddD, AddR and done are Moore decodes of state/idx and are glitch-free relative to clk.
- Outside READ and CLR: AddR=0, WE=0, AddD=0.
- start outside IDLE is ignored; there is no queuing.
- idx never wraps past NREGS-1; the terminal comparison precedes any increment.

## Timing
- Reset values: state=IDLE, idx=0, busy=0, done=0, out_valid=0, out_data=0, out_index=0, WE=0, AddR=0, AddD=0, DataD=0.
- busy rises the cycle after the start edge and falls the cycle after DONE.
- Dump with out_ready held at 1: 2 cycles per register, 64 cycles plus 1 DONE cycle. The first out_valid appears 2 cycles after start.
- Backpressure: each cycle out_ready=0 in HOLD adds one cycle. No data is lost or reordered.
- Clear: 31 write cycles (idx 1..31) plus 1 DONE cycle.
- rst mid-command: returns to the reset state on the next edge. out_valid drops with no handshake. A write issued in the same cycle as rst still completes in the register file; no further writes follow.
- rst takes priority over start in the same cycle.

## Structure
- The shared rv32 package holds XLEN, the register-address width, the register count, and the state enum.
- Single module; no sub-module required.

## Test plan
- Preload xN=N*0x01010101 with x0=0, start with clear=0 and out_ready=1 → 32 words with out_index 0..31 and matching data, done pulses at cycle 66.
- Same dump with out_ready toggling 1-of-3 → identical sequence; out_data stable whenever out_valid=1 and out_ready=0.
- Preload all registers with 0xDEADBEEF, start with clear=1 → WE high 31 cycles with AddD 1..31 and DataD=0; a subsequent dump returns all zeros.
- start pulsed during HOLD → ignored; sequence and done timing unchanged.
- rst asserted at out_index=10 in HOLD → next cycle busy=0, out_valid=0, WE=0; a new dump then starts again from index 0.
- start and rst in the same cycle → block remains in IDLE with busy=0.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared RV32 register-file constants and the maintenance-port state encoding.
package regfile_dump_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_AW    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_HOLD,
        ST_CLR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Command, register-file port and dump-stream signals of the maintenance port.
interface regfile_dump_if
    import regfile_dump_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = RF_AW
);
    logic            start;
    logic            clear;
    logic            busy;
    logic            done;
    logic [AW-1:0]   AddR;
    logic [XLEN-1:0] DataR;
    logic            WE;
    logic [AW-1:0]   AddD;
    logic [XLEN-1:0] DataD;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [AW-1:0]   out_index;

    // master: the dump engine; slave: core/register file/consumer side
    modport master (
        input  start, clear, DataR, out_ready,
        output busy, done, AddR, WE, AddD, DataD, out_valid, out_data, out_index
    );
    modport slave (
        output start, clear, DataR, out_ready,
        input  busy, done, AddR, WE, AddD, DataD, out_valid, out_data, out_index
    );
endinterface

// File: rtl/regfile_dump.sv
// Walks the register file: streams x0..x(NREGS-1) out over valid/ready, or zeroes x1..x(NREGS-1).
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int AW    = RF_AW
) (
    input  logic           clk,
    input  logic           rst,
    regfile_dump_if.master bus
);

    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_idx, w_idx_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [XLEN-1:0] r_out_data, w_out_data_nxt;
    logic [AW-1:0]   r_out_index, w_out_index_nxt;
    logic [AW-1:0]   r_addr_r, r_addr_d;
    logic            r_we, r_busy, r_done;
    logic            w_last;

    assign w_last = (r_idx == AW'(NREGS - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_index_nxt = r_out_index;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.clear) begin
                        w_idx_nxt   = AW'(1);
                        w_state_nxt = ST_CLR;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: begin
                w_out_data_nxt  = bus.DataR;
                w_out_index_nxt = r_idx;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + AW'(1);
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_CLR: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Port controls are decoded from next state and registered, so they leave flops clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_addr_r    <= '0;
            r_addr_d    <= '0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_index <= w_out_index_nxt;
            r_addr_r    <= (w_state_nxt == ST_READ) ? w_idx_nxt : '0;
            r_addr_d    <= (w_state_nxt == ST_CLR)  ? w_idx_nxt : '0;
            r_we        <= (w_state_nxt == ST_CLR);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.AddR      = r_addr_r;
    assign bus.WE        = r_we;
    assign bus.AddD      = r_addr_d;
    assign bus.DataD     = '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_index = r_out_index;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural 32x32 register file.
module tb_regfile_dump;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_dump_if #(.XLEN(32), .AW(5)) bus ();

    regfile_dump #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rf [0:31];
    logic [31:0] exp_rf [0:31];
    logic        pre_en = 1'b0;
    logic        pre_mode = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    assign bus.DataR = rf[bus.AddR];

    // x0 stays zero; preload pattern 0 is N*0x01010101, pattern 1 is 0xDEADBEEF
    always @(posedge clk) begin
        if (pre_en) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= (i == 0) ? 32'h0 : (pre_mode ? 32'hDEADBEEF : 32'(i) * 32'h01010101);
        end else if (bus.WE && bus.AddD != 5'd0) begin
            rf[bus.AddD] <= bus.DataD;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic m);
        pre_en = 1'b1;
        pre_mode = m;
        tick();
        pre_en = 1'b0;
        for (int i = 0; i < 32; i++)
            exp_rf[i] = (i == 0) ? 32'h0 : (m ? 32'hDEADBEEF : 32'(i) * 32'h01010101);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        n_chk++;
        if ({bus.busy, bus.done, bus.out_valid, bus.WE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got busy/done/valid/we=%b want 0000",
                     {bus.busy, bus.done, bus.out_valid, bus.WE});
        end
        n_chk++;
        if (bus.AddR !== 5'd0 || bus.AddD !== 5'd0 || bus.DataD !== 32'h0 ||
            bus.out_data !== 32'h0 || bus.out_index !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data got AddR=%0d AddD=%0d DataD=%h out_data=%h out_index=%0d want all 0",
                     bus.AddR, bus.AddD, bus.DataD, bus.out_data, bus.out_index);
        end
        rst = 1'b0;
        tick();
    endtask

    // mode 0: ready always 1; mode 1: ready 1-of-3; mode 2: ready 1 plus start pulse in HOLD
    task automatic test_dump(input int mode, input string tag);
        int n, done_cyc, first_vld;
        logic held;
        logic [31:0] held_d;
        logic [4:0] held_i;
        n = 0; done_cyc = -1; first_vld = -1; held = 1'b0; held_d = '0; held_i = '0;
        bus.clear = 1'b0;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.AddR !== 5'd0) begin
            n_fail++;
            $display("FAIL %s first_cycle got busy=%b valid=%b AddR=%0d want 1 0 0",
                     tag, bus.busy, bus.out_valid, bus.AddR);
        end
        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            bus.out_ready = (mode == 1) ? (c % 3 == 0) : 1'b1;
            if (mode == 2 && c == 10) begin
                bus.start = 1'b1;
                bus.clear = 1'b1;
            end
            if (held && bus.out_valid) begin
                n_chk++;
                if (bus.out_data !== held_d || bus.out_index !== held_i) begin
                    n_fail++;
                    $display("FAIL %s stall_stable got %0d:%h want %0d:%h",
                             tag, bus.out_index, bus.out_data, held_i, held_d);
                end
            end
            held = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                n_chk++;
                if (n >= 32) begin
                    n_fail++;
                    $display("FAIL %s extra_word got index %0d want no word", tag, bus.out_index);
                end else if (bus.out_index !== 5'(n) || bus.out_data !== exp_rf[n]) begin
                    n_fail++;
                    $display("FAIL %s word got %0d:%h want %0d:%h",
                             tag, bus.out_index, bus.out_data, n, exp_rf[n]);
                end
                n++;
            end else if (bus.out_valid) begin
                held = 1'b1;
                held_d = bus.out_data;
                held_i = bus.out_index;
            end
            tick();
            bus.start = 1'b0;
            bus.clear = 1'b0;
            if (first_vld < 0 && bus.out_valid) first_vld = c;
            if (bus.done) done_cyc = c;
        end
        n_chk++;
        if (n != 32) begin
            n_fail++;
            $display("FAIL %s word_count got %0d want 32", tag, n);
        end
        n_chk++;
        if (first_vld != 1) begin
            n_fail++;
            $display("FAIL %s first_valid_cycle got %0d want 1", tag, first_vld);
        end
        n_chk++;
        if (mode != 1 ? (done_cyc != 64) : (done_cyc < 65)) begin
            n_fail++;
            $display("FAIL %s done_cycle got %0d want %s", tag, done_cyc, mode != 1 ? "64" : ">64");
        end
        tick();
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done got busy=%b done=%b want 0 0", tag, bus.busy, bus.done);
        end
    endtask

    task automatic test_clear();
        int we_cnt, nxt, done_cyc;
        preload(1'b1);
        we_cnt = 0; nxt = 1; done_cyc = -1;
        bus.clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.clear = 1'b0;
        for (int c = 0; c <= 100 && done_cyc < 0; c++) begin
            if (bus.WE) begin
                n_chk++;
                if (bus.AddD !== 5'(nxt) || bus.DataD !== 32'h0 || bus.AddR !== 5'd0) begin
                    n_fail++;
                    $display("FAIL clear_write got AddD=%0d DataD=%h AddR=%0d want %0d 0 0",
                             bus.AddD, bus.DataD, bus.AddR, nxt);
                end
                nxt++;
                we_cnt++;
            end
            if (bus.done) done_cyc = c;
            else tick();
        end
        n_chk++;
        if (we_cnt != 31 || done_cyc != 31) begin
            n_fail++;
            $display("FAIL clear_count got writes=%0d done_cycle=%0d want 31 31", we_cnt, done_cyc);
        end
        tick();
        n_chk++;
        if (bus.busy !== 1'b0 || bus.WE !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_end got busy=%b WE=%b want 0 0", bus.busy, bus.WE);
        end
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
        test_dump(0, "dump_after_clear");
    endtask

    task automatic test_rst_mid_dump();
        logic found;
        found = 1'b0;
        preload(1'b0);
        bus.out_ready = 1'b1;
        bus.clear = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (bus.out_valid && bus.out_index == 5'd10) found = 1'b1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_mid_reach got no index 10 want index 10 in HOLD");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({bus.busy, bus.out_valid, bus.WE, bus.done} !== 4'b0000 || bus.out_index !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_state got busy/valid/we/done=%b index=%0d want 0000 0",
                     {bus.busy, bus.out_valid, bus.WE, bus.done}, bus.out_index);
        end
        tick();
        test_dump(0, "dump_after_rst");
    endtask

    task automatic test_rst_in_clear();
        logic found;
        found = 1'b0;
        preload(1'b1);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.clear = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (bus.WE && bus.AddD == 5'd5) found = 1'b1;
            else tick();
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_clr_reach got no write to x5 want write to x5");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_chk++;
        if (bus.WE !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_clr_state got WE=%b busy=%b want 0 0", bus.WE, bus.busy);
        end
        // x1..x5 were written (x5 in the reset cycle), the rest keep 0xDEADBEEF
        for (int i = 0; i < 32; i++) exp_rf[i] = (i <= 5) ? 32'h0 : 32'hDEADBEEF;
        test_dump(0, "dump_after_rst_clear");
    endtask

    task automatic test_start_rst();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.clear = 1'b0;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_rst_busy got %b want 0", bus.busy);
        end
        tick();
        tick();
        n_chk++;
        if ({bus.busy, bus.out_valid, bus.WE, bus.AddR} !== 8'h00) begin
            n_fail++;
            $display("FAIL start_rst_idle got busy/valid/we/AddR=%b want 0",
                     {bus.busy, bus.out_valid, bus.WE, bus.AddR});
        end
    endtask

    initial begin
        test_reset();
        preload(1'b0);
        test_dump(0, "dump_ready");
        test_dump(1, "dump_backpressure");
        test_dump(2, "dump_start_in_hold");
        test_clear();
        test_rst_mid_dump();
        test_rst_in_clear();
        test_start_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
